// File: rtl/inst_mem_ctrl_pkg.sv
// Shared definitions for the run-time-loadable instruction memory:
// bus widths, enable levels, memory depth and loader state encodings.
package inst_mem_ctrl_pkg;

    localparam int          RegBus         = 32;
    localparam int          InstAddrBus    = 32;
    localparam int          InstBus        = 32;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        RstEnable      = 1'b1;
    localparam logic        ChipEnable     = 1'b1;
    localparam int          InstMemNumLog2 = 10;

    typedef enum logic [1:0] {
        LdIdle = 2'd0,
        LdLoad = 2'd1,
        LdDone = 2'd2
    } ld_state_e;

    // Running load checksum: every written word folds in by XOR.
    function automatic logic [RegBus-1:0] csum_fold(input logic [RegBus-1:0] csum,
                                                    input logic [InstBus-1:0] word);
        return csum ^ word;
    endfunction

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Fetch port and byte-stream loader port of the instruction memory.
// The master side is the core plus the program source; the slave side is inst_mem_ctrl.
interface inst_mem_ctrl_if
    import inst_mem_ctrl_pkg::*;
#(
    parameter int MEM_LOG2 = InstMemNumLog2
);
    logic                   ce_i;
    logic [InstAddrBus-1:0] addr_i;
    logic [InstBus-1:0]     data_o;
    logic                   ld_start_i;
    logic [MEM_LOG2:0]      ld_len_i;
    logic                   ld_valid_i;
    logic [7:0]             ld_data_i;
    logic                   ld_ready_o;
    logic                   ld_done_o;
    logic                   core_hold_o;
    logic [RegBus-1:0]      ld_csum_o;
    logic                   fetch_err_o;

    modport master (
        output ce_i, addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_data_i,
        input  data_o, ld_ready_o, ld_done_o, core_hold_o, ld_csum_o, fetch_err_o
    );

    modport slave (
        input  ce_i, addr_i, ld_start_i, ld_len_i, ld_valid_i, ld_data_i,
        output data_o, ld_ready_o, ld_done_o, core_hold_o, ld_csum_o, fetch_err_o
    );
endinterface

// File: rtl/inst_mem_ctrl_byte_word_asm.sv
// Assembles accepted stream bytes big-endian into 32-bit words and pulses
// word_valid_o in the same cycle the fourth byte of a word is accepted.
module byte_word_asm
    import inst_mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               byte_en,
    input  logic [7:0]         byte_data,
    output logic [InstBus-1:0] word_o,
    output logic               word_valid_o
);
    logic [1:0]  bcnt_r;
    logic [23:0] shift_r;

    // Byte counter and shift register; a new load or reset drops any partial word.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            bcnt_r  <= 2'd0;
            shift_r <= 24'h00_0000;
        end else if (clr) begin
            bcnt_r  <= 2'd0;
            shift_r <= 24'h00_0000;
        end else if (byte_en) begin
            bcnt_r  <= bcnt_r + 2'd1;
            shift_r <= {shift_r[15:0], byte_data};
        end else begin
            bcnt_r  <= bcnt_r;
            shift_r <= shift_r;
        end
    end

    // The incoming byte completes the word so memory can be written on the accepting edge.
    assign word_o       = {shift_r, byte_data};
    assign word_valid_o = byte_en && (bcnt_r == 2'd3);

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory with a zero-latency fetch port and a byte-stream program
// loader that holds the core in reset while a new image is written.
module inst_mem_ctrl
    import inst_mem_ctrl_pkg::*;
#(
    parameter int MEM_LOG2 = InstMemNumLog2
)(
    input  logic           clk,
    input  logic           rst,
    inst_mem_ctrl_if.slave bus
);
    localparam int                Depth   = 1 << MEM_LOG2;
    localparam logic [MEM_LOG2:0] LenMax  = {1'b1, {MEM_LOG2{1'b0}}};
    localparam logic [MEM_LOG2:0] PtrZero = {(MEM_LOG2 + 1){1'b0}};
    localparam logic [MEM_LOG2:0] PtrOne  = {{MEM_LOG2{1'b0}}, 1'b1};

    logic [InstBus-1:0]  mem_r [0:Depth-1];
    ld_state_e           state_r;
    ld_state_e           state_s;
    logic [MEM_LOG2:0]   len_r;
    logic [MEM_LOG2:0]   wptr_r;
    logic [MEM_LOG2:0]   len_in_s;
    logic [RegBus-1:0]   csum_r;
    logic                fetch_err_r;
    logic [InstBus-1:0]  data_s;
    logic [MEM_LOG2-1:0] idx_s;
    logic                in_range_s;
    logic                start_s;
    logic                ready_s;
    logic                accept_s;
    logic [InstBus-1:0]  word_s;
    logic                word_valid_s;
    logic                last_word_s;
    logic                unused_addr_s;

    assign idx_s         = bus.addr_i[MEM_LOG2+1:2];
    assign in_range_s    = (bus.addr_i[InstAddrBus-1:MEM_LOG2+2] == {(InstAddrBus - MEM_LOG2 - 2){1'b0}});
    assign unused_addr_s = ^bus.addr_i[1:0];
    assign start_s       = (state_r == LdIdle) && bus.ld_start_i;
    assign ready_s       = (state_r == LdLoad) && (len_r != PtrZero);
    assign accept_s      = ready_s && bus.ld_valid_i;
    assign last_word_s   = word_valid_s && ((wptr_r + PtrOne) == len_r);

    byte_word_asm u_asm (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_s),
        .byte_en      (accept_s),
        .byte_data    (bus.ld_data_i),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // Requested lengths beyond the memory depth fill the whole array and stop.
    always_comb begin
        len_in_s = bus.ld_len_i;
        if (bus.ld_len_i > LenMax) begin
            len_in_s = LenMax;
        end else begin
            len_in_s = bus.ld_len_i;
        end
    end

    // Loader next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LdIdle: begin
                if (bus.ld_start_i) begin
                    state_s = LdLoad;
                end else begin
                    state_s = LdIdle;
                end
            end
            LdLoad: begin
                if ((len_r == PtrZero) || last_word_s) begin
                    state_s = LdDone;
                end else begin
                    state_s = LdLoad;
                end
            end
            LdDone:  state_s = LdIdle;
            default: state_s = LdIdle;
        endcase
    end

    // Loader state, length, write pointer, checksum and sticky fetch error.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r     <= LdIdle;
            len_r       <= PtrZero;
            wptr_r      <= PtrZero;
            csum_r      <= ZeroWord;
            fetch_err_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_s) begin
                len_r  <= len_in_s;
                wptr_r <= PtrZero;
                csum_r <= ZeroWord;
            end else if (word_valid_s) begin
                len_r  <= len_r;
                wptr_r <= wptr_r + PtrOne;
                csum_r <= csum_fold(csum_r, word_s);
            end else begin
                len_r  <= len_r;
                wptr_r <= wptr_r;
                csum_r <= csum_r;
            end
            // Starting a load clears the flag even if this cycle's fetch is also bad.
            if (start_s) begin
                fetch_err_r <= 1'b0;
            end else if ((bus.ce_i == ChipEnable) && !in_range_s) begin
                fetch_err_r <= 1'b1;
            end else begin
                fetch_err_r <= fetch_err_r;
            end
        end
    end

    // Program storage; contents survive reset so an aborted load keeps finished words.
    always_ff @(posedge clk) begin
        if (word_valid_s) begin
            mem_r[wptr_r[MEM_LOG2-1:0]] <= word_s;
        end
    end

    // Zero-latency fetch; anything not servable returns a NOP.
    always_comb begin
        data_s = ZeroWord;
        if ((bus.ce_i == ChipEnable) && (state_r != LdLoad) && in_range_s) begin
            data_s = mem_r[idx_s];
        end else begin
            data_s = ZeroWord;
        end
    end

    assign bus.data_o      = data_s;
    assign bus.ld_ready_o  = ready_s;
    assign bus.ld_done_o   = (state_r == LdDone);
    assign bus.core_hold_o = (state_r != LdIdle);
    assign bus.ld_csum_o   = csum_r;
    assign bus.fetch_err_o = fetch_err_r;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the memory and loader.
module tb_inst_mem_ctrl;
    import inst_mem_ctrl_pkg::*;

    localparam int ML    = 10;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;

    inst_mem_ctrl_if #(.MEM_LOG2(ML)) bus ();
    inst_mem_ctrl #(.MEM_LOG2(ML)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int hs_count = 0;
    bit chk_en   = 1'b0;

    // Reference model: plain memory array, a byte queue and a load phase.
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_phase = 0;   // 0 idle, 1 loading, 2 done pulse
    int          m_len   = 0;
    int          m_words = 0;
    logic [7:0]  m_bytes [$];
    logic [31:0] m_csum  = 32'h0;
    bit          m_err   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit          start_now;
        logic [31:0] w;
        start_now = (m_phase == 0) && bus.ld_start_i;
        if (rst) begin
            m_phase = 0; m_csum = 32'h0; m_err = 1'b0; m_words = 0;
            m_bytes.delete();
        end else begin
            if (bus.ce_i && (bus.addr_i[31:12] != 20'h0)) m_err = 1'b1;
            if (start_now) m_err = 1'b0;
            case (m_phase)
                0: if (bus.ld_start_i) begin
                    m_len   = (int'(bus.ld_len_i) > DEPTH) ? DEPTH : int'(bus.ld_len_i);
                    m_words = 0; m_csum = 32'h0; m_bytes.delete();
                    m_phase = 1;
                end
                1: if (m_len == 0) m_phase = 2;
                   else if (bus.ld_valid_i) begin
                       m_bytes.push_back(bus.ld_data_i);
                       if (m_bytes.size() == 4) begin
                           w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
                           m_mem[m_words] = w; m_known[m_words] = 1'b1;
                           m_csum = m_csum ^ w;
                           m_words++;
                           m_bytes.delete();
                           if (m_words == m_len) m_phase = 2;
                       end
                   end
                default: m_phase = 0;
            endcase
        end
    endtask

    // One clock: count handshakes away from the edge, then advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        if (bus.ld_valid_i && bus.ld_ready_o) hs_count++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fetch_chk(input string name, input logic ce, input logic [31:0] addr,
                             input logic [31:0] exp);
        bus.ce_i = ce; bus.addr_i = addr;
        #1;
        chk(name, bus.data_o, exp);
        tick();
    endtask

    task automatic send(input logic [7:0] b);
        bus.ld_valid_i = 1'b1; bus.ld_data_i = b;
        tick();
        bus.ld_valid_i = 1'b0;
    endtask

    task automatic start_load(input int len);
        bus.ld_len_i = 11'(len); bus.ld_start_i = 1'b1;
        tick();
        bus.ld_start_i = 1'b0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int idx;
            bit served;
            idx    = int'(bus.addr_i[11:2]);
            served = bus.ce_i && (m_phase != 1) && (bus.addr_i[31:12] == 20'h0);
            if (!served) chk("cyc_data", bus.data_o, 32'h0);
            else if (m_known[idx]) chk("cyc_data", bus.data_o, m_mem[idx]);
            chk("cyc_ready", {31'h0, bus.ld_ready_o}, {31'h0, (m_phase == 1) && (m_len != 0)});
            chk("cyc_done",  {31'h0, bus.ld_done_o},  {31'h0, m_phase == 2});
            chk("cyc_hold",  {31'h0, bus.core_hold_o}, {31'h0, m_phase != 0});
            chk("cyc_csum",  bus.ld_csum_o, m_csum);
            chk("cyc_err",   {31'h0, bus.fetch_err_o}, {31'h0, m_err});
        end
    end

    initial begin
        rst = 1'b1;
        bus.ce_i = 1'b0; bus.addr_i = 32'h0; bus.ld_start_i = 1'b0; bus.ld_len_i = 11'd0;
        bus.ld_valid_i = 1'b0; bus.ld_data_i = 8'h00;
        tick(); tick();
        rst = 1'b0; chk_en = 1'b1;
        #1;
        chk("rst_data",  bus.data_o, 32'h0);
        chk("rst_ready", {31'h0, bus.ld_ready_o}, 32'h0);
        chk("rst_hold",  {31'h0, bus.core_hold_o}, 32'h0);
        chk("rst_csum",  bus.ld_csum_o, 32'h0);

        // Two-word load, back-to-back bytes.
        start_load(2);
        send(8'h34); send(8'h08); send(8'h00); send(8'h05);
        send(8'h24); send(8'h02); send(8'h00); send(8'h07);
        chk("load2_done", {31'h0, bus.ld_done_o}, 32'h1);
        chk("load2_csum", bus.ld_csum_o, 32'h100A_0002);
        chk("load2_model_csum", m_csum, 32'h100A_0002);
        chk("load2_model_mem1", m_mem[1], 32'h2402_0007);
        tick();
        chk("load2_hold_fall", {31'h0, bus.core_hold_o}, 32'h0);
        chk("load2_done_fall", {31'h0, bus.ld_done_o}, 32'h0);

        fetch_chk("fetch_a4", 1'b1, 32'h4, 32'h2402_0007);
        fetch_chk("fetch_a7", 1'b1, 32'h7, 32'h2402_0007);
        fetch_chk("fetch_a0", 1'b1, 32'h0, 32'h3408_0005);
        fetch_chk("fetch_ce0", 1'b0, 32'h4, 32'h0);

        // Out-of-range fetch sets the sticky error.
        fetch_chk("oor_data", 1'b1, 32'h0000_1000, 32'h0);
        bus.ce_i = 1'b0; bus.addr_i = 32'h0;
        #1;
        chk("oor_err", {31'h0, bus.fetch_err_o}, 32'h1);
        tick(); tick(); tick();
        chk("oor_err_sticky", {31'h0, bus.fetch_err_o}, 32'h1);
        chk("oor_model_err", {31'h0, m_err}, 32'h1);

        // One-word load with a 3-cycle valid gap mid-word; the start clears the error.
        start_load(1);
        chk("start_clears_err", {31'h0, bus.fetch_err_o}, 32'h0);
        send(8'hAA); send(8'hBB);
        tick(); tick(); tick();
        send(8'hCC); send(8'hDD);
        chk("gap_csum", bus.ld_csum_o, 32'hAABB_CCDD);
        tick();
        fetch_chk("gap_word", 1'b1, 32'h0, 32'hAABB_CCDD);

        // Abort a two-word load after 6 bytes.
        bus.ce_i = 1'b0;
        start_load(2);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        chk("abort_hold", {31'h0, bus.core_hold_o}, 32'h0);
        chk("abort_csum", bus.ld_csum_o, 32'h0);
        fetch_chk("abort_w0", 1'b1, 32'h0, 32'h1122_3344);
        fetch_chk("abort_w1", 1'b1, 32'h4, 32'h2402_0007);

        // Zero-length load: done two cycles after start, no bytes taken.
        bus.ce_i = 1'b0;
        hs_count = 0;
        start_load(0);
        bus.ld_valid_i = 1'b1; bus.ld_data_i = 8'h5A;
        #1;
        chk("len0_ready", {31'h0, bus.ld_ready_o}, 32'h0);
        chk("len0_not_yet", {31'h0, bus.ld_done_o}, 32'h0);
        tick();
        chk("len0_done", {31'h0, bus.ld_done_o}, 32'h1);
        tick();
        bus.ld_valid_i = 1'b0;
        chk("len0_no_bytes", 32'(hs_count), 32'd0);

        // A start pulse in LOAD is ignored.
        start_load(1);
        send(8'h01); send(8'h02);
        bus.ld_start_i = 1'b1; bus.ld_len_i = 11'd3;
        send(8'h03);
        bus.ld_start_i = 1'b0;
        send(8'h04);
        chk("ignore_start_done", {31'h0, bus.ld_done_o}, 32'h1);
        chk("ignore_start_csum", bus.ld_csum_o, 32'h0102_0304);
        tick();

        // Oversized length clamps to the full memory.
        hs_count = 0;
        start_load(2047);
        for (int i = 0; i < 4096 + 3; i++) begin
            bus.ld_valid_i = 1'b1; bus.ld_data_i = 8'($urandom);
            tick();
        end
        bus.ld_valid_i = 1'b0;
        chk("clamp_bytes", 32'(hs_count), 32'd4096);
        chk("clamp_model_words", 32'(m_words), 32'd1024);
        chk("clamp_idle", {31'h0, bus.core_hold_o}, 32'h0);

        // Randomized traffic over fetch, load and reset.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            bus.ce_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) bus.addr_i = $urandom | 32'h0000_1000;
            else bus.addr_i = 32'($urandom_range(0, 4095));
            bus.ld_start_i = ($urandom_range(0, 24) == 0);
            bus.ld_len_i   = 11'($urandom_range(0, 6));
            bus.ld_valid_i = ($urandom_range(0, 3) != 0);
            bus.ld_data_i  = 8'($urandom);
            tick();
        end
        rst = 1'b0; bus.ld_start_i = 1'b0; bus.ld_valid_i = 1'b0; bus.ce_i = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Instruction-memory responder at the far end of the core's fetch port (`rom_ce_o`/`rom_addr_o`/`rom_data_i`). It serves instruction words to the core in the same cycle the address is presented. It also contains a byte-stream loader that fills the memory with a program while holding the core. The block sits at SoC top level, beside `openmips`, and replaces a static ROM image with a run-time-loadable one.

## Interface
- `MEM_LOG2`, 10, log2 of memory depth in 32-bit words (1024 words).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ce_i`  in  1  fetch enable, driven by the core's `rom_ce_o`.
- `addr_i`  in  32  byte address of the fetch, driven by the core's `rom_addr_o`.
- `data_o`  out  32  instruction word returned to the core's `rom_data_i`.
- `ld_start_i`  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- `ld_len_i`  in  MEM_LOG2+1  number of words to load, sampled with `ld_start_i`.
- `ld_valid_i`  in  1  byte-stream valid.
- `ld_data_i`  in  8  byte-stream data.
- `ld_ready_o`  out  1  byte accepted when `ld_valid_i && ld_ready_o`.
- `ld_done_o`  out  1  one-cycle pulse when a load completes.
- `core_hold_o`  out  1  high while loading; the top level ORs it into the core's `rst`.
- `ld_csum_o`  out  32  XOR of all words written by the current or last load.
- `fetch_err_o`  out  1  sticky flag for an out-of-range fetch; cleared by `rst` or `ld_start_i`.

## Operation
- **Fetch path (combinational).**
  - Word index is `addr_i[MEM_LOG2+1:2]`; `addr_i[1:0]` is ignored.
  - `data_o = mem[index]` when all three hold: `ce_i`=1, FSM not in LOAD, and `addr_i[31:MEM_LOG2+2]`==0.
  - Otherwise `data_o`=32'h0, which is a NOP.
  - When `ce_i`=1, an out-of-range address sets `fetch_err_o` on the next edge.
- **Loader FSM:** IDLE, LOAD, DONE.
  - **IDLE → LOAD** on `ld_start_i`. On that edge:
    - latch `len = min(ld_len_i, 2^MEM_LOG2)`;
    - clear word pointer `wptr`, byte count `bcnt`, `ld_csum_o` and `fetch_err_o`.
  - **LOAD**, when `len`==0: go to DONE on the next edge without accepting any bytes.
  - **LOAD**, when `len`>0:
    - `ld_ready_o`=1.
    - Each accepted byte shifts into the assembly register big-endian: the first byte becomes bits 31:24.
    - On the 4th byte of a word: write the assembled word to `mem[wptr]`, set `ld_csum_o ^= word`, `wptr++`, `bcnt=0`.
    - When that write brings `wptr` to `len`, go to DONE.
  - **DONE:** `ld_done_o`=1 for exactly one cycle, then return to IDLE.
  - `ld_start_i` is ignored in LOAD and DONE.
- **Holding the core.**
  - `core_hold_o`=1 in LOAD and DONE, and 0 in IDLE.
  - The core leaves reset on the cycle after `ld_done_o` and fetches from address 0.
- **Reset.**
  - `rst` sets: FSM=IDLE, `wptr`=0, `bcnt`=0, assembly register=0, `ld_csum_o`=0, `fetch_err_o`=0, `ld_ready_o`=0, `ld_done_o`=0, `core_hold_o`=0.
  - Memory contents are not cleared.
  - `rst` during LOAD abandons the load. Words already written stay written; a partial word is discarded.

## Timing
- Fetch latency is 0 cycles (combinational). This matches the core's IF/ID register, which samples `rom_data_i` in the same cycle as the PC.
- Memory write occurs on the edge that accepts the 4th byte; the word is readable combinationally from the next cycle.
- Minimum load time is 4·`len` accepted-byte cycles, plus 1 cycle for the start edge, plus 1 cycle for DONE.
- Back-pressure: the stream may drop `ld_valid_i` at any time. `ld_ready_o` never depends combinationally on `ld_valid_i`.
- `ld_len_i` greater than 2^MEM_LOG2 is clamped: the load fills the whole memory and stops at the last word.

## Structure
- Shared defines file provides: `RegBus`, `InstAddrBus`, `InstBus`, `ZeroWord`, `RstEnable`, `ChipEnable`.
- Add `InstMemNumLog2` (=10) and the FSM state encodings `LdIdle`/`LdLoad`/`LdDone` to the shared defines.
- One sub-module: `byte_word_asm`, which holds the byte counter, shift register and word-valid pulse. The memory array and FSM stay in `inst_mem_ctrl`.

## Test plan
- **Reset:** assert `rst` for 2 cycles. Expect `data_o`=0, `ld_ready_o`=0, `core_hold_o`=0, `ld_csum_o`=0.
- **Load 2 words:**
  - Stimulus: `ld_len_i`=2, bytes 34 08 00 05 24 02 00 07 back-to-back.
  - Expect: `mem[0]`=32'h34080005, `mem[1]`=32'h24020007, `ld_csum_o`=32'h100A0002.
  - Expect `ld_done_o` one cycle high, and `core_hold_o` falling on the cycle after.
- **Fetch:** with that image, `ce_i`=1.
  - `addr_i`=4 → `data_o`=32'h24020007.
  - `addr_i`=7 → 32'h24020007 (low bits ignored).
  - `ce_i`=0 → 0.
- **Out of range:** `addr_i`=32'h00001000 with `ce_i`=1 → `data_o`=0; `fetch_err_o`=1 next cycle and stays high until the next `ld_start_i`.
- **Back-pressure and abort:**
  - Gap `ld_valid_i` low for 3 cycles mid-word: the word is still assembled correctly.
  - Assert `rst` after 6 bytes of a 2-word load: `mem[0]` is written, `mem[1]` is unchanged, FSM is IDLE.
- **Edge lengths:**
  - `ld_len_i`=0 → `ld_done_o` 2 cycles after start, with no bytes accepted.
  - `ld_len_i`=2047 → clamps at 1024 words.
  - `ld_start_i` during LOAD → ignored.
